// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - sequential instruction prefetch queue with redirect flush
module inst_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        cpu_clock,
  input  logic        cpu_reset_b,
  input  logic        ins_fetch_req,
  input  logic [31:0] ins_pc,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic        fetch_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [31:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [31:0]   pf_addr, rsp_addr, exp_pc, last_inst;
  logic [OW-1:0] outst, discard;
  logic          running;

  logic          hit, redirect, rsp, issue, push, pop;
  logic [CW:0]   occupancy;

  assign redirect  = ins_fetch_req && (ins_pc != exp_pc);
  assign hit       = ins_fetch_req && (cnt != '0) && (q_addr[head] == ins_pc);
  assign rsp       = mem_rvalid && (outst != '0);
  // Discarded responses never land in the queue, so only live requests reserve space.
  assign occupancy = (CW+1)'(cnt) + (CW+1)'(outst - discard);

  assign mem_req   = running && !redirect && (outst < OW'(MAX_OUTST))
                     && (occupancy < (CW+1)'(DEPTH));
  assign mem_addr  = pf_addr;
  assign issue     = mem_req && mem_gnt;
  assign pop       = hit && !redirect;
  assign push      = rsp && (discard == '0) && !redirect;

  assign inst_valid  = running && hit;
  assign fetch_stall = running && ins_fetch_req && !hit;
  assign instruction = hit ? q_data[head] : (ins_fetch_req ? 32'h0 : last_inst);

  always_ff @(posedge cpu_clock or negedge cpu_reset_b) begin
    if (!cpu_reset_b) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      pf_addr   <= RESET_PC;
      rsp_addr  <= RESET_PC;
      exp_pc    <= RESET_PC;
      last_inst <= 32'h0;
      outst     <= '0;
      discard   <= '0;
      running   <= 1'b0;
    end else begin
      running <= 1'b1;
      if (redirect) begin
        // Everything still in flight belongs to the abandoned stream.
        head     <= '0;
        tail     <= '0;
        cnt      <= '0;
        pf_addr  <= ins_pc;
        rsp_addr <= ins_pc;
        exp_pc   <= ins_pc;
        outst    <= outst - OW'(rsp);
        discard  <= outst - OW'(rsp);
      end else begin
        if (pop) begin
          head      <= head + PW'(1);
          last_inst <= q_data[head];
          exp_pc    <= ins_pc + 32'd4;
        end
        if (push) begin
          tail     <= tail + PW'(1);
          rsp_addr <= rsp_addr + 32'd4;
        end
        cnt <= cnt + CW'(push) - CW'(pop);
        if (issue)
          pf_addr <= pf_addr + 32'd4;
        outst <= outst + OW'(issue) - OW'(rsp);
        if (rsp && (discard != '0))
          discard <= discard - OW'(1);
      end
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (push) begin
      q_addr[tail] <= rsp_addr;
      q_data[tail] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - randomized bench for inst_prefetch_queue against a queue-level model
module tb_inst_prefetch_queue;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        cpu_clock = 1'b0;
  logic        cpu_reset_b = 1'b1;
  logic        ins_fetch_req = 1'b0;
  logic [31:0] ins_pc = 32'h0;
  logic [31:0] instruction;
  logic        inst_valid, fetch_stall, mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  inst_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)) dut (
    .cpu_clock(cpu_clock), .cpu_reset_b(cpu_reset_b), .ins_fetch_req(ins_fetch_req),
    .ins_pc(ins_pc), .instruction(instruction), .inst_valid(inst_valid),
    .fetch_stall(fetch_stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  int checks = 0, errors = 0;

  // reference model: words ready for the cpu, plus counts of live/dropped requests
  ent_t        mq[$];
  int          m_live, m_disc;
  logic [31:0] m_pf, m_rsp, m_exp, m_last;
  bit          m_run;

  // in-order memory with per-request ready cycle
  logic [31:0] mem_a[$];
  longint      mem_t[$];
  int          lat_lo, lat_hi, gnt_pct;
  longint      cyc;

  logic [31:0] cpu_pc;
  int          hits, first_hit;
  logic [31:0] hit_inst;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mem_a.delete();
    mem_t.delete();
    m_live = 0; m_disc = 0;
    m_pf = 32'h0; m_rsp = 32'h0; m_exp = 32'h0; m_last = 32'h0;
    m_run = 1'b0;
    cpu_pc = 32'h0;
    cyc = 0;
    first_hit = -1;
  endtask

  task automatic apply_reset();
    cpu_reset_b   = 1'b0;
    ins_fetch_req = 1'b1;
    ins_pc        = 32'h40;
    mem_rvalid    = 1'b0;
    mem_gnt       = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_fetch_stall", fetch_stall, 1'b0);
    model_reset();
    repeat (2) @(posedge cpu_clock);
    @(negedge cpu_clock);
    cpu_reset_b = 1'b1;
    ins_pc      = 32'h0;
    #1;
    chk("mem_req_before_first_edge", mem_req, 1'b0);
    @(posedge cpu_clock);
    #1;
    m_run = 1'b1;
  endtask

  // one cycle: drive at edge+1, compare at edge+2, advance model, wait to next edge+1
  task automatic step(input bit req);
    bit          redir, hit, ereq, rv;
    logic [31:0] rd, einst;
    ins_fetch_req = req;
    ins_pc        = cpu_pc;
    mem_gnt       = ($urandom_range(99) < gnt_pct);
    rv = (mem_a.size() > 0) && (mem_t[0] <= cyc);
    if (rv) begin
      rd = mdata(mem_a[0]);
      void'(mem_a.pop_front());
      void'(mem_t.pop_front());
    end else begin
      rd = $urandom;
    end
    mem_rvalid = rv;
    mem_rdata  = rd;
    #1;
    redir = req && (cpu_pc != m_exp);
    hit   = req && !redir && (mq.size() > 0) && (mq[0].addr == cpu_pc);
    ereq  = m_run && !redir && ((m_live + m_disc) < MAX_OUTST) && ((mq.size() + m_live) < DEPTH);
    einst = hit ? mq[0].data : (req ? 32'h0 : m_last);
    chk("inst_valid", inst_valid, hit);
    chk("fetch_stall", fetch_stall, m_run && req && !hit);
    chk("instruction", instruction, einst);
    chk("mem_req", mem_req, ereq);
    if (ereq) chk("mem_addr", mem_addr, m_pf);
    if (redir) begin
      mq.delete();
      m_disc = m_live + m_disc - (rv ? 1 : 0);
      m_live = 0;
      m_pf = cpu_pc; m_rsp = cpu_pc; m_exp = cpu_pc;
    end else begin
      if (hit) begin
        m_last   = mq[0].data;
        hit_inst = instruction;
        void'(mq.pop_front());
        m_exp  = cpu_pc + 32'd4;
        cpu_pc = cpu_pc + 32'd4;
        hits++;
        if (first_hit < 0) first_hit = int'(cyc);
      end
      if (rv) begin
        if (m_disc > 0) m_disc--;
        else begin
          mq.push_back('{addr: m_rsp, data: rd});
          m_rsp = m_rsp + 32'd4;
          m_live--;
        end
      end
      if (ereq && mem_gnt) begin
        mem_a.push_back(m_pf);
        mem_t.push_back(cyc + longint'($urandom_range(lat_hi, lat_lo)));
        m_pf = m_pf + 32'd4;
        m_live++;
      end
    end
    cyc++;
    @(posedge cpu_clock);
    #1;
  endtask

  initial begin
    int h0, n;
    hits = 0;
    hit_inst = 32'h0;
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    #1;
    apply_reset();

    // streaming from reset with single-cycle memory
    repeat (12) step(1'b1);
    chk("first_hit_cycle", 32'(first_hit), 32'd2);
    chk("hits_stream", 32'(hits), 32'd10);

    // long latency: outstanding limit throttles requests
    lat_lo = 5; lat_hi = 5;
    repeat (30) step(1'b1);

    // processor hold fills the queue, then drains back to back
    lat_lo = 1; lat_hi = 2;
    repeat (10) step(1'b0);
    chk("mem_req_queue_full", mem_req, 1'b0);
    h0 = hits;
    repeat (4) step(1'b1);
    chk("back_to_back_hits", 32'(hits - h0), 32'd4);

    // jump back to 0 from 0x10 while requests are in flight
    lat_lo = 4; lat_hi = 4;
    cpu_pc = 32'h0;
    for (int i = 0; i < 60 && cpu_pc != 32'h10; i++) step(1'b1);
    chk("reached_0x10", cpu_pc, 32'h10);
    cpu_pc = 32'h0;
    h0 = hits;
    n = 0;
    for (int i = 0; i < 30 && hits == h0; i++) begin
      step(1'b1);
      n++;
    end
    chk("jump_first_word", hit_inst, mdata(32'h0));
    chk("jump_latency_ge2", 32'(n >= 3), 32'd1);

    // redirect near the top of the address space wraps to 0
    lat_lo = 1; lat_hi = 3;
    cpu_pc = 32'hFFFF_FFF8;
    h0 = hits;
    for (int i = 0; i < 40 && hits < h0 + 3; i++) step(1'b1);
    chk("wrap_pc", cpu_pc, 32'h4);
    chk("wrap_word0", hit_inst, mdata(32'h0));

    // randomized traffic with random stalls, grants, latencies and branches
    lat_lo = 1; lat_hi = 6; gnt_pct = 70;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 4)
        cpu_pc = ($urandom_range(1) == 1) ? (32'hFFFF_FFF0 + ($urandom & 32'hC))
                                          : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(99) < 80);
    end

    // asynchronous reset mid-burst
    lat_lo = 2; lat_hi = 2; gnt_pct = 100;
    repeat (6) step(1'b1);
    #2;
    cpu_reset_b = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 1'b0);
    chk("async_inst_valid", inst_valid, 1'b0);
    chk("async_fetch_stall", fetch_stall, 1'b0);
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    repeat (8) step(1'b1);
    chk("restart_first_hit", 32'(first_hit), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
